multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Sequential main control unit for the multi-cycle RV32I core.
- Produces the 2-bit ALUOp consumed by ALU_control: 00 add, 01 branch, 10 R-type, 11 I-immediate.
- Also produces every datapath enable and mux select, and handshakes with a variable-latency unified memory.
- Sits between the instruction register (IR) opcode field and the datapath.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
opcode  in  7  IR[6:0]; stable from DECODE until the next IR write
mem_ready  in  1  memory completes the current request this cycle
branch_taken  in  1  branch compare result from the ALU, valid in BRANCH
mem_req  out  1  memory request
mem_we  out  1  write strobe, qualified by mem_req
iord  out  1  address select: 0 PC, 1 ALUOut
ir_write  out  1  load IR and MDR from memory
pc_write  out  1  PC load enable
pc_src  out  2  00 ALU result, 01 ALUOut
alu_src_a  out  2  00 rs1, 01 old PC, 10 zero, 11 PC
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
alu_op  out  2  ALUOp to ALU_control
reg_write  out  1  register file write enable
wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC
illegal  out  1  sticky illegal-opcode flag
retire  out  1  one-cycle pulse on the final cycle of each instruction
instret  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: clk only; reset synchronous, active-high. Reset has priority over everything, including mid-handshake. Next state IDLE, illegal=0, instret=0.
- Output timing: outputs are combinational from the state register and opcode. Every output is 0 in IDLE and whenever unlisted below.
- States (3-bit): IDLE, FETCH, DECODE, EXEC, BRANCH, MEM, WB, TRAP.
- IDLE: go unconditionally to FETCH next cycle.
- FETCH: mem_req=1, iord=0, alu_src_a=11, alu_src_b=10, alu_op=00.
  - Hold while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00 (PC+4); go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/JAL target into ALUOut). Next state by opcode class:
  - BRANCH (1100011) -> BRANCH
  - R (0110011), I (0010011), LOAD (0000011), STORE (0100011), LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111) -> EXEC
  - anything else -> TRAP
- EXEC:
  - R: a=00, b=00, alu_op=10; -> WB.
  - I: a=00, b=01, alu_op=11; -> WB.
  - LOAD/STORE: a=00, b=01, alu_op=00; -> MEM.
  - LUI: a=10, b=01, alu_op=00; -> WB.
  - AUIPC: a=01, b=01, alu_op=00; -> WB.
  - JAL: reg_write=1, wb_sel=10, pc_write=1, pc_src=01; retire; -> FETCH.
  - JALR: a=00, b=01, alu_op=00, reg_write=1, wb_sel=10, pc_write=1, pc_src=00; retire; -> FETCH.
  - For JAL/JALR the link value is the already-incremented PC. It is captured on the same edge as the PC update.
- BRANCH: a=00, b=00, alu_op=01, pc_src=01, pc_write=branch_taken; retire; -> FETCH.
- MEM: mem_req=1, iord=1, mem_we=(opcode==STORE).
  - Hold while mem_ready=0.
  - When mem_ready=1: LOAD writes MDR (ir_write stays 0; the datapath loads MDR every accepted read) and goes to WB. STORE retires and goes to FETCH.
- WB: reg_write=1, wb_sel=01 for LOAD, 00 otherwise; retire; -> FETCH.
- TRAP: illegal=1. Stays until reset; mem_ready is ignored; no retire.
- Handshake: mem_req, iord and mem_we stay constant until mem_ready is sampled high. mem_ready is ignored when mem_req=0. No back-to-back requests without an intervening non-request cycle, except STORE MEM -> FETCH.
- instret: increments by 1 on each retire edge and wraps to 0 after all-ones.
- Cycle counts with zero-wait memory: R/I/LUI/AUIPC 4; LOAD 5; STORE 4; BRANCH/JAL/JALR 3.

Decomposition:
- defines.v gains: state encodings, RV32I opcode constants, ALUOp codes (ALUOP_ADD/BRANCH/RTYPE/ITYPE), and alu_src_a/alu_src_b/pc_src/wb_sel select codes.
- One sub-module: opcode_class_decoder, purely combinational. Maps opcode to a one-hot instruction class with an illegal bit. Reused by DECODE and EXEC/MEM/WB.

Test Plan:
1. Reset, then R-type (0110011) with mem_ready tied high.
   - States go IDLE, FETCH, DECODE, EXEC, WB, FETCH.
   - EXEC alu_op=10; WB reg_write=1, wb_sel=00; retire pulses once; instret=1.
2. LOAD with mem_ready low for 3 MEM cycles.
   - mem_req=1, iord=1, mem_we=0 held for 4 cycles.
   - WB wb_sel=01; 8 cycles from FETCH to retire.
3. BRANCH, run once with branch_taken=1 and once with 0.
   - BRANCH state: alu_op=01, pc_src=01, pc_write=1 then 0 respectively.
   - Both retire after 3 cycles.
4. JAL.
   - EXEC asserts reg_write=1, wb_sel=10, pc_write=1, pc_src=01 in the same cycle.
   - Next state FETCH; instret increments.
5. Opcode 0000000.
   - DECODE -> TRAP; illegal=1 and all other outputs 0 for 20 cycles while mem_ready toggles.
   - instret frozen; reset clears illegal.
6. Reset asserted during a stalled MEM store, and instret wrap.
   - Reset mid-MEM: next cycle is IDLE with mem_req=0, instret=0.
   - Separately with CNT_W=4: 16 retires return instret to 0.

Source files
------------

// File: rtl/multicycle_main_control_pkg.sv
// Purpose: shared constants and types for the multi-cycle RV32I main control
//          unit: FSM state encodings, RV32I opcodes, ALUOp codes, datapath
//          mux select codes and the one-hot instruction-class type.
// Ports:   none (package).
package multicycle_main_control_pkg;

    // FSM state encodings (3-bit)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_BRANCH = 3'd4;
    localparam logic [2:0] ST_MEM    = 3'd5;
    localparam logic [2:0] ST_WB     = 3'd6;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    // RV32I major opcodes
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALUOp codes consumed by ALU_control
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SRC_A_RS1   = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_ZERO  = 2'b10;
    localparam logic [1:0] SRC_A_PC    = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

    // Register write-back select
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // One-hot instruction class; exactly one bit is set for any opcode
    typedef struct packed {
        logic r;
        logic i;
        logic load;
        logic store;
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic branch;
        logic illegal;
    } opc_class_t;

    // Instructions that go through the MEM state after EXEC
    function automatic logic is_mem_op(input opc_class_t c);
        return c.load | c.store;
    endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Purpose: bundle between the main control unit and the datapath/memory.
//          master = control unit (drives enables/selects),
//          slave  = datapath side (drives opcode, mem_ready, branch_taken).
// Signals: opcode, mem_ready, branch_taken (to control);
//          mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
//          alu_src_b, alu_op, reg_write, wb_sel, illegal, retire, instret
//          (from control).
interface multicycle_main_control_if #(
    parameter int CNT_W = 32
) ();
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             illegal;
    logic             retire;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, mem_ready, branch_taken,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               illegal, retire, instret
    );

    modport slave (
        output opcode, mem_ready, branch_taken,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               illegal, retire, instret
    );
endinterface

// File: rtl/multicycle_main_control_opcode_class_decoder.sv
// Purpose: purely combinational map from the IR opcode field to a one-hot
//          instruction class; unknown opcodes set the illegal bit.
// Ports:   i_opcode (7) opcode field IR[6:0]
//          o_class      one-hot class (opc_class_t)
module multicycle_main_control_opcode_class_decoder
    import multicycle_main_control_pkg::*;
(
    input  logic [6:0] i_opcode,
    output opc_class_t o_class
);

    // Opcode to one-hot class lookup
    always_comb begin
        o_class = '0;
        case (i_opcode)
            OPC_R:      o_class.r       = 1'b1;
            OPC_I:      o_class.i       = 1'b1;
            OPC_LOAD:   o_class.load    = 1'b1;
            OPC_STORE:  o_class.store   = 1'b1;
            OPC_LUI:    o_class.lui     = 1'b1;
            OPC_AUIPC:  o_class.auipc   = 1'b1;
            OPC_JAL:    o_class.jal     = 1'b1;
            OPC_JALR:   o_class.jalr    = 1'b1;
            OPC_BRANCH: o_class.branch  = 1'b1;
            default:    o_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Purpose: sequential main control unit of the multi-cycle RV32I core.
//          An 8-state FSM produces every datapath enable/select, the ALUOp
//          for ALU_control, handshakes with a variable-latency unified
//          memory and counts retired instructions.
// Ports:   i_clk   system clock
//          i_reset synchronous active-high reset
//          io_bus  master side of multicycle_main_control_if
// Outputs are combinational from the state register and opcode (plus
// mem_ready/branch_taken for the completion-qualified enables); instret is
// a register.
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    multicycle_main_control_if.master      io_bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_instret;
    opc_class_t       w_class;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic [1:0] w_wb_sel;
    logic       w_illegal;
    logic       w_retire;

    multicycle_main_control_opcode_class_decoder u_decoder (
        .i_opcode (io_bus.opcode),
        .o_class  (w_class)
    );

    // State register and retired-instruction counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instret <= r_instret + CNT_ONE;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = PC_SRC_ALU;
        w_alu_src_a  = SRC_A_RS1;
        w_alu_src_b  = SRC_B_RS2;
        w_alu_op     = ALUOP_ADD;
        w_reg_write  = 1'b0;
        w_wb_sel     = WB_ALUOUT;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
            end

            ST_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed when
                // the memory accepts the request.
                w_mem_req   = 1'b1;
                w_iord      = 1'b0;
                w_alu_src_a = SRC_A_PC;
                w_alu_src_b = SRC_B_FOUR;
                w_alu_op    = ALUOP_ADD;
                if (io_bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_pc_src     = PC_SRC_ALU;
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_DECODE: begin
                // old PC + imm lands in ALUOut as the branch/JAL target
                w_alu_src_a = SRC_A_OLDPC;
                w_alu_src_b = SRC_B_IMM;
                w_alu_op    = ALUOP_ADD;
                if (w_class.branch) begin
                    w_next_state = ST_BRANCH;
                end else if (w_class.illegal) begin
                    w_next_state = ST_TRAP;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (w_class.r) begin
                    w_alu_src_a  = SRC_A_RS1;
                    w_alu_src_b  = SRC_B_RS2;
                    w_alu_op     = ALUOP_RTYPE;
                    w_next_state = ST_WB;
                end else if (w_class.i) begin
                    w_alu_src_a  = SRC_A_RS1;
                    w_alu_src_b  = SRC_B_IMM;
                    w_alu_op     = ALUOP_ITYPE;
                    w_next_state = ST_WB;
                end else if (is_mem_op(w_class)) begin
                    w_alu_src_a  = SRC_A_RS1;
                    w_alu_src_b  = SRC_B_IMM;
                    w_alu_op     = ALUOP_ADD;
                    w_next_state = ST_MEM;
                end else if (w_class.lui) begin
                    w_alu_src_a  = SRC_A_ZERO;
                    w_alu_src_b  = SRC_B_IMM;
                    w_alu_op     = ALUOP_ADD;
                    w_next_state = ST_WB;
                end else if (w_class.auipc) begin
                    w_alu_src_a  = SRC_A_OLDPC;
                    w_alu_src_b  = SRC_B_IMM;
                    w_alu_op     = ALUOP_ADD;
                    w_next_state = ST_WB;
                end else if (w_class.jal) begin
                    // link = already-incremented PC, written on the same
                    // edge that loads the target from ALUOut
                    w_reg_write  = 1'b1;
                    w_wb_sel     = WB_PC;
                    w_pc_write   = 1'b1;
                    w_pc_src     = PC_SRC_ALUOUT;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (w_class.jalr) begin
                    w_alu_src_a  = SRC_A_RS1;
                    w_alu_src_b  = SRC_B_IMM;
                    w_alu_op     = ALUOP_ADD;
                    w_reg_write  = 1'b1;
                    w_wb_sel     = WB_PC;
                    w_pc_write   = 1'b1;
                    w_pc_src     = PC_SRC_ALU;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    // opcode changed under us without an IR write
                    w_next_state = ST_TRAP;
                end
            end

            ST_BRANCH: begin
                w_alu_src_a  = SRC_A_RS1;
                w_alu_src_b  = SRC_B_RS2;
                w_alu_op     = ALUOP_BRANCH;
                w_pc_src     = PC_SRC_ALUOUT;
                w_pc_write   = io_bus.branch_taken;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end

            ST_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = w_class.store;
                if (io_bus.mem_ready) begin
                    if (w_class.load) begin
                        w_next_state = ST_WB;
                    end else if (w_class.store) begin
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_TRAP;
                    end
                end else begin
                    w_next_state = ST_MEM;
                end
            end

            ST_WB: begin
                w_reg_write  = 1'b1;
                w_wb_sel     = w_class.load ? WB_MDR : WB_ALUOUT;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end

            ST_TRAP: begin
                // only reset leaves TRAP, so illegal is sticky
                w_illegal    = 1'b1;
                w_next_state = ST_TRAP;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign io_bus.mem_req   = w_mem_req;
    assign io_bus.mem_we    = w_mem_we;
    assign io_bus.iord      = w_iord;
    assign io_bus.ir_write  = w_ir_write;
    assign io_bus.pc_write  = w_pc_write;
    assign io_bus.pc_src    = w_pc_src;
    assign io_bus.alu_src_a = w_alu_src_a;
    assign io_bus.alu_src_b = w_alu_src_b;
    assign io_bus.alu_op    = w_alu_op;
    assign io_bus.reg_write = w_reg_write;
    assign io_bus.wb_sel    = w_wb_sel;
    assign io_bus.illegal   = w_illegal;
    assign io_bus.retire    = w_retire;
    assign io_bus.instret   = r_instret;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Testbench for multicycle_main_control. Two DUTs (CNT_W=32 and CNT_W=4)
// share identical stimulus. Each instruction is expanded by the bench into
// its expected per-cycle output list from the instruction's class and the
// chosen memory wait counts; a compare process checks every cycle.
module tb_multicycle_main_control;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       retire;
    } outv_t;

    typedef struct packed {
        outv_t       o;
        logic [31:0] instret;
    } exp_t;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] AUI_OP = 7'b0010111;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] JR_OP  = 7'b1100111;
    localparam logic [6:0] BR_OP  = 7'b1100011;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc_len;
    logic [31:0] model_cnt;
    exp_t exp_q[$];

    multicycle_main_control_if #(.CNT_W(32)) bus32 ();
    multicycle_main_control_if #(.CNT_W(4))  bus4  ();

    multicycle_main_control #(.CNT_W(32)) dut32 (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus32)
    );

    multicycle_main_control #(.CNT_W(4)) dut4 (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive this cycle's inputs and record what the outputs must be.
    task automatic push_cur(input logic [6:0] opc, input logic mr, input logic bt, input outv_t o);
        exp_t e;
        bus32.opcode = opc; bus32.mem_ready = mr; bus32.branch_taken = bt;
        bus4.opcode  = opc; bus4.mem_ready  = mr; bus4.branch_taken  = bt;
        e.o = o;
        e.instret = model_cnt;
        exp_q.push_back(e);
        if (o.retire) model_cnt = model_cnt + 32'd1;
        cyc_len++;
    endtask

    task automatic step(input logic [6:0] opc, input logic mr, input logic bt, input outv_t o);
        @(negedge clk);
        push_cur(opc, mr, bt, o);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Per-cycle comparison against the expected list
    always @(negedge clk) begin
        exp_t  e;
        outv_t a32;
        outv_t a4;
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a32 = {bus32.mem_req, bus32.mem_we, bus32.iord, bus32.ir_write, bus32.pc_write,
                   bus32.pc_src, bus32.alu_src_a, bus32.alu_src_b, bus32.alu_op,
                   bus32.reg_write, bus32.wb_sel, bus32.illegal, bus32.retire};
            a4  = {bus4.mem_req, bus4.mem_we, bus4.iord, bus4.ir_write, bus4.pc_write,
                   bus4.pc_src, bus4.alu_src_a, bus4.alu_src_b, bus4.alu_op,
                   bus4.reg_write, bus4.wb_sel, bus4.illegal, bus4.retire};
            chk("outputs", 64'(a32), 64'(e.o));
            chk("outputs_w4", 64'(a4), 64'(e.o));
            chk("instret", 64'(bus32.instret), 64'(e.instret));
            chk("instret_w4", 64'(bus4.instret), 64'(e.instret[3:0]));
        end
    end

    // Reset for one edge (mem_ready high to show reset wins), then the IDLE cycle.
    task automatic do_reset();
        outv_t o;
        @(negedge clk);
        reset = 1'b1;
        bus32.mem_ready = 1'b1; bus4.mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 32'd0;
        o = '0;
        push_cur(7'($urandom), rbit(), rbit(), o);
    endtask

    task automatic fetch_decode(input logic [6:0] opc, input int fw);
        outv_t o;
        for (int k = 0; k <= fw; k++) begin
            o = '0;
            o.mem_req = 1'b1; o.a = 2'b11; o.b = 2'b10;
            if (k == fw) begin
                o.ir_write = 1'b1; o.pc_write = 1'b1;
            end
            step(7'($urandom), (k == fw), rbit(), o);
        end
        o = '0;
        o.a = 2'b01; o.b = 2'b01;
        step(opc, rbit(), rbit(), o);
    endtask

    // Expand one legal instruction into its expected cycles; returns length.
    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw,
                             input logic taken, output int ncyc);
        outv_t o;
        logic  to_wb;
        cyc_len = 0;
        to_wb = 1'b0;
        fetch_decode(opc, fw);
        o = '0;
        case (opc)
            BR_OP: begin
                o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_write = taken; o.retire = 1'b1;
                step(opc, rbit(), taken, o);
            end
            R_OP:   begin o.alu_op = 2'b10; step(opc, rbit(), rbit(), o); to_wb = 1'b1; end
            I_OP:   begin o.b = 2'b01; o.alu_op = 2'b11; step(opc, rbit(), rbit(), o); to_wb = 1'b1; end
            LUI_OP: begin o.a = 2'b10; o.b = 2'b01; step(opc, rbit(), rbit(), o); to_wb = 1'b1; end
            AUI_OP: begin o.a = 2'b01; o.b = 2'b01; step(opc, rbit(), rbit(), o); to_wb = 1'b1; end
            JAL_OP: begin
                o.reg_write = 1'b1; o.wb_sel = 2'b10; o.pc_write = 1'b1; o.pc_src = 2'b01;
                o.retire = 1'b1;
                step(opc, rbit(), rbit(), o);
            end
            JR_OP: begin
                o.b = 2'b01; o.reg_write = 1'b1; o.wb_sel = 2'b10; o.pc_write = 1'b1;
                o.retire = 1'b1;
                step(opc, rbit(), rbit(), o);
            end
            LD_OP, ST_OP: begin
                o.b = 2'b01;
                step(opc, rbit(), rbit(), o);
                for (int k = 0; k <= mw; k++) begin
                    o = '0;
                    o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (opc == ST_OP);
                    o.retire = (k == mw) && (opc == ST_OP);
                    step(opc, (k == mw), rbit(), o);
                end
                to_wb = (opc == LD_OP);
            end
            default: begin
                $display("FAIL bench_opcode: got %h expected a legal opcode", opc);
                n_errors++;
            end
        endcase
        if (to_wb) begin
            o = '0;
            o.reg_write = 1'b1; o.wb_sel = (opc == LD_OP) ? 2'b01 : 2'b00; o.retire = 1'b1;
            step(opc, rbit(), rbit(), o);
        end
        ncyc = cyc_len;
    endtask

    task automatic run_trap(input logic [6:0] opc, input int n);
        outv_t o;
        fetch_decode(opc, 0);
        for (int k = 0; k < n; k++) begin
            o = '0;
            o.illegal = 1'b1;
            step(opc, k[0], rbit(), o);
        end
    endtask

    // Store stalled in MEM, then reset before the memory answers.
    task automatic store_then_reset();
        outv_t o;
        fetch_decode(ST_OP, 0);
        o = '0; o.b = 2'b01;
        step(ST_OP, rbit(), rbit(), o);
        for (int k = 0; k < 2; k++) begin
            o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = 1'b1;
            step(ST_OP, 1'b0, rbit(), o);
        end
        do_reset();
    endtask

    logic [6:0] opc_tab [9];
    int         len_tab [9];

    initial begin
        int n;
        logic [31:0] frozen;
        n_checks = 0;
        n_errors = 0;
        model_cnt = 32'd0;
        cyc_len = 0;
        reset = 1'b1;
        bus32.opcode = 7'd0; bus32.mem_ready = 1'b0; bus32.branch_taken = 1'b0;
        bus4.opcode  = 7'd0; bus4.mem_ready  = 1'b0; bus4.branch_taken  = 1'b0;

        opc_tab = '{R_OP, I_OP, LUI_OP, AUI_OP, ST_OP, LD_OP, BR_OP, JAL_OP, JR_OP};
        len_tab = '{4, 4, 4, 4, 4, 5, 3, 3, 3};

        do_reset();
        #3 chk("reset_instret", 64'(bus32.instret), 64'd0);

        // 1. R-type, zero wait
        run_instr(R_OP, 0, 0, 1'b0, n);
        chk("r_len", 64'(n), 64'd4);
        @(posedge clk); #1 chk("r_instret", 64'(bus32.instret), 64'd1);

        // 2. LOAD with 3 stalled MEM cycles
        run_instr(LD_OP, 0, 3, 1'b0, n);
        chk("load_stall_len", 64'(n), 64'd8);

        // 3. BRANCH taken / not taken
        run_instr(BR_OP, 0, 0, 1'b1, n);
        chk("br_taken_len", 64'(n), 64'd3);
        run_instr(BR_OP, 0, 0, 1'b0, n);
        chk("br_not_len", 64'(n), 64'd3);

        // 4. JAL
        run_instr(JAL_OP, 0, 0, 1'b0, n);
        chk("jal_len", 64'(n), 64'd3);
        @(posedge clk); #1 chk("jal_instret", 64'(bus32.instret), 64'd5);

        // Zero-wait length of every class
        for (int k = 0; k < 9; k++) begin
            run_instr(opc_tab[k], 0, 0, rbit(), n);
            chk("class_len", 64'(n), 64'(len_tab[k]));
        end

        // 5. Illegal opcode: sticky trap, counter frozen
        @(posedge clk); #1 frozen = bus32.instret;
        chk("pre_trap_instret", 64'(frozen), 64'd14);
        run_trap(7'b0000000, 20);
        @(posedge clk); #1;
        chk("trap_illegal", 64'(bus32.illegal), 64'd1);
        chk("trap_instret", 64'(bus32.instret), 64'(frozen));
        do_reset();
        #3 chk("reset_clears_illegal", 64'(bus32.illegal), 64'd0);

        // 6. Reset in the middle of a stalled store
        run_instr(R_OP, 0, 0, 1'b0, n);
        store_then_reset();
        #3;
        chk("midmem_reset_req", 64'(bus32.mem_req), 64'd0);
        chk("midmem_reset_instret", 64'(bus32.instret), 64'd0);

        // 16 retires wrap the 4-bit counter to zero
        for (int k = 0; k < 16; k++) run_instr(JAL_OP, 0, 0, 1'b0, n);
        @(posedge clk); #1;
        chk("wrap_w4", 64'(bus4.instret), 64'd0);
        chk("wrap_w32", 64'(bus32.instret), 64'd16);

        // Randomized instruction stream with random memory latency
        for (int k = 0; k < 200; k++) begin
            run_instr(opc_tab[$urandom_range(0, 8)], $urandom_range(0, 3),
                      $urandom_range(0, 3), rbit(), n);
        end

        repeat (3) @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
